qcldpc_enc_sequencer: RTL and testbench

Control FSM that sequences one QC-LDPC encode through the encoder datapath. The datapath is the cyclic shifters, the proto-matrix shift ROM and the parity accumulators. The block latches the requested lifting size, then accepts NUM_INFO_BLKS info blocks over a valid/ready handshake, driving the ROM address and the accumulator enable/clear for each one. It then triggers the parity-solve step and streams NUM_PAR_BLKS parity blocks out. It sits between the upstream data source and the encoder core; it carries no data, only control.

---
 rtl/qcldpc_pkg.sv | 29 ++
 rtl/qcldpc_rom_addr_gen.sv | 23 ++
 rtl/qcldpc_enc_sequencer.sv | 155 +++++++++++++++
 tb/tb_qcldpc_enc_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcldpc_pkg.sv
// Shared types, default geometry and one-hot helpers for the QC-LDPC encoder sequencer.
package qcldpc_pkg;

    localparam int DEF_NUM_Z         = 3;
    localparam int DEF_NUM_INFO_BLKS = 20;
    localparam int DEF_NUM_PAR_BLKS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SOLVE,
        EMIT
    } seq_state_t;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Index of the highest set bit; only meaningful when is_onehot(v) holds.
    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/qcldpc_rom_addr_gen.sv
// Shift-ROM address: z_idx*Z_STRIDE + blk_cnt*BLK_STRIDE, built only from constant shifts and adds.
module qcldpc_rom_addr_gen #(
    parameter int          Z_IDX_W    = 2,
    parameter int          BLK_W      = 5,
    parameter int          ADDR_W     = 9,
    parameter int unsigned Z_STRIDE   = 96,
    parameter int unsigned BLK_STRIDE = 4
) (
    input  logic [Z_IDX_W-1:0] z_idx,
    input  logic [BLK_W-1:0]   blk_cnt,
    output logic [ADDR_W-1:0]  rom_addr
);

    always_comb begin
        rom_addr = '0;
        // NOTE: blocking '=' is right here: each loop pass must see the sum built by the previous one.
        for (int i = 0; i < 32; i++) begin
            if (Z_STRIDE[i])   rom_addr = rom_addr + (ADDR_W'(z_idx) << i);
            if (BLK_STRIDE[i]) rom_addr = rom_addr + (ADDR_W'(blk_cnt) << i);
        end
    end

endmodule

// File: rtl/qcldpc_enc_sequencer.sv
// Control FSM sequencing one QC-LDPC encode: latch Z, load info blocks, solve, emit parity.
// Optional abort input enabled by defining QCLDPC_SEQ_ABORT_EN.
module qcldpc_enc_sequencer
    import qcldpc_pkg::*;
#(
    parameter int NUM_Z          = DEF_NUM_Z,
    parameter int NUM_INFO_BLKS  = DEF_NUM_INFO_BLKS,
    parameter int NUM_PAR_BLKS   = DEF_NUM_PAR_BLKS,
    localparam int TOTAL_BLKS    = NUM_INFO_BLKS + NUM_PAR_BLKS,
    localparam int ROM_ADDR_W    = $clog2(TOTAL_BLKS * NUM_PAR_BLKS * NUM_Z),
    localparam int Z_IDX_W       = $clog2(NUM_Z),
    localparam int BLK_W         = $clog2(TOTAL_BLKS),
    localparam int PAR_W         = $clog2(NUM_PAR_BLKS)
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [NUM_Z-1:0]      req_z,
    input  logic                  start,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [Z_IDX_W-1:0]    z_idx,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [BLK_W-1:0]      blk_cnt,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic                  solve_en,
    output logic [PAR_W-1:0]      par_sel,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  done
`ifdef QCLDPC_SEQ_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    seq_state_t         state_q, state_d;
    logic [Z_IDX_W-1:0] z_q, z_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [PAR_W-1:0]   par_q, par_d;
    logic               done_q, done_d;
    logic               abort_i;

`ifdef QCLDPC_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            z_q     <= '0;
            blk_q   <= '0;
            par_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' so every register updates from pre-edge values, whatever the order.
            state_q <= state_d;
            z_q     <= z_d;
            blk_q   <= blk_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        z_d      = z_q;
        blk_d    = blk_q;
        par_d    = par_q;
        done_d   = 1'b0;
        cfg_err  = 1'b0;
        acc_clr  = 1'b0;
        s_ready  = 1'b0;
        solve_en = 1'b0;
        m_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_onehot(32'(req_z))) begin
                        z_d     = Z_IDX_W'(onehot_to_idx(32'(req_z)));
                        blk_d   = '0;
                        par_d   = '0;
                        acc_clr = 1'b1;
                        state_d = LOAD;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Dropping ready under abort keeps acc_en == s_valid & s_ready while discarding the beat.
                s_ready = !abort_i;
                if (s_valid && s_ready) begin
                    blk_d = blk_q + 1'b1;
                    if (blk_q == BLK_W'(NUM_INFO_BLKS - 1)) state_d = SOLVE;
                end
            end
            SOLVE: begin
                solve_en = 1'b1;
                par_d    = '0;
                state_d  = EMIT;
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (par_q == PAR_W'(NUM_PAR_BLKS - 1)) begin
                        state_d = IDLE;
                        blk_d   = '0;
                        par_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        par_d = par_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            blk_d   = '0;
            par_d   = '0;
            done_d  = 1'b0;
            acc_clr = 1'b1;
        end
    end

    assign busy    = (state_q != IDLE);
    assign z_idx   = z_q;
    assign blk_cnt = blk_q;
    assign par_sel = par_q;
    assign done    = done_q;
    assign acc_en  = s_valid && s_ready;
    assign m_last  = m_valid && (par_q == PAR_W'(NUM_PAR_BLKS - 1));

    qcldpc_rom_addr_gen #(
        .Z_IDX_W    (Z_IDX_W),
        .BLK_W      (BLK_W),
        .ADDR_W     (ROM_ADDR_W),
        .Z_STRIDE   (TOTAL_BLKS * NUM_PAR_BLKS),
        .BLK_STRIDE (NUM_PAR_BLKS)
    ) u_rom_addr_gen (
        .z_idx    (z_q),
        .blk_cnt  (blk_q),
        .rom_addr (rom_addr)
    );

endmodule

// File: tb/tb_qcldpc_enc_sequencer.sv
// Self-checking bench for qcldpc_enc_sequencer: IDLE decode table, directed corner sequences,
// and a randomized run against a count-based reference model.
module tb_qcldpc_enc_sequencer;

    localparam int NZ = 3;
    localparam int NI = 20;
    localparam int NP = 4;
    localparam int NT = NI + NP;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [2:0] req_z;
    logic       start;
    logic       busy;
    logic       cfg_err;
    logic [1:0] z_idx;
    logic       s_valid;
    logic       s_ready;
    logic [4:0] blk_cnt;
    logic [8:0] rom_addr;
    logic       acc_clr;
    logic       acc_en;
    logic       solve_en;
    logic [1:0] par_sel;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       done;
`ifdef QCLDPC_SEQ_ABORT_EN
    logic       abort;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    qcldpc_enc_sequencer dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .req_z    (req_z),
        .start    (start),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .z_idx    (z_idx),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .blk_cnt  (blk_cnt),
        .rom_addr (rom_addr),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .solve_en (solve_en),
        .par_sel  (par_sel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .done     (done)
`ifdef QCLDPC_SEQ_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_cfg_err"},  cfg_err,  0);
        check({tag, "_z_idx"},    z_idx,    0);
        check({tag, "_s_ready"},  s_ready,  0);
        check({tag, "_blk_cnt"},  blk_cnt,  0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_acc_clr"},  acc_clr,  0);
        check({tag, "_acc_en"},   acc_en,   0);
        check({tag, "_solve_en"}, solve_en, 0);
        check({tag, "_par_sel"},  par_sel,  0);
        check({tag, "_m_valid"},  m_valid,  0);
        check({tag, "_m_last"},   m_last,   0);
        check({tag, "_done"},     done,     0);
    endtask

    // Leaves the bench at a falling edge with reset released and all inputs idle.
    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        req_z   = 3'b000;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bit seen;
        seen    = 0;
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            #1;
            if (done) seen = 1;
            @(negedge CLK);
        end
        check(name, seen, 1);
    endtask

    // Reference model: progress of a codeword kept as counts of accepted info beats and parity beats.
    bit md_active, md_solved, md_done;
    int md_got, md_sent, md_zi;

    function automatic bit ref_onehot(input logic [2:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int ref_pos(input logic [2:0] v);
        int p;
        p = 0;
        for (int i = 0; i < NZ; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic model_check();
        bit in_load, in_solve, in_emit;
        int col;
        in_load  = md_active && (md_got < NI);
        in_solve = md_active && (md_got == NI) && !md_solved;
        in_emit  = md_active && md_solved;
        col      = md_active ? md_got : 0;
        check("rnd_busy",     busy,     md_active);
        check("rnd_cfg_err",  cfg_err,  !md_active && start && !ref_onehot(req_z));
        check("rnd_acc_clr",  acc_clr,  !md_active && start && ref_onehot(req_z));
        check("rnd_z_idx",    z_idx,    md_zi);
        check("rnd_s_ready",  s_ready,  in_load);
        check("rnd_acc_en",   acc_en,   in_load && s_valid);
        check("rnd_blk_cnt",  blk_cnt,  col);
        check("rnd_rom_addr", rom_addr, md_zi * NT * NP + col * NP);
        check("rnd_solve_en", solve_en, in_solve);
        check("rnd_m_valid",  m_valid,  in_emit);
        check("rnd_par_sel",  par_sel,  in_emit ? md_sent : 0);
        check("rnd_m_last",   m_last,   in_emit && (md_sent == NP - 1));
        check("rnd_done",     done,     md_done);
    endtask

    task automatic model_update();
        md_done = 0;
        if (!md_active) begin
            if (start && ref_onehot(req_z)) begin
                md_active = 1;
                md_got    = 0;
                md_solved = 0;
                md_sent   = 0;
                md_zi     = ref_pos(req_z);
            end
        end else if (md_got < NI) begin
            if (s_valid) md_got++;
        end else if (!md_solved) begin
            md_solved = 1;
        end else if (m_ready) begin
            md_sent++;
            if (md_sent == NP) begin
                md_active = 0;
                md_done   = 1;
            end
        end
    endtask

    typedef struct {
        logic       start;
        logic [2:0] req_z;
        logic       exp_cfg_err;
        logic       exp_acc_clr;
        logic       exp_busy_next;
        logic [1:0] exp_z_next;
    } idle_vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_vec_t vecs[8];
        int        cnt;
        int        ncw;
        bit        seen;

        vecs[0] = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[1] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 2'd1};
        vecs[2] = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[3] = '{1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};

`ifdef QCLDPC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        rst_n   = 1'b0;
        start   = 1'b0;
        req_z   = 3'b000;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check_all_zero("reset");
        do_reset();

        // IDLE start decode, one vector per fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            start = vecs[i].start;
            req_z = vecs[i].req_z;
            #1;
            check($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].exp_cfg_err);
            check($sformatf("vec%0d_acc_clr", i), acc_clr, vecs[i].exp_acc_clr);
            @(negedge CLK);
            start = 1'b0;
            #1;
            check($sformatf("vec%0d_busy", i),      busy,    vecs[i].exp_busy_next);
            check($sformatf("vec%0d_z_idx", i),     z_idx,   vecs[i].exp_z_next);
            check($sformatf("vec%0d_cfg_pulse", i), cfg_err, 0);
            @(negedge CLK);
        end

        // Full codeword at z=1, back-to-back beats; cycle 0 is the start cycle.
        do_reset();
        req_z   = 3'b010;
        start   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c <= 26; c++) begin
            if (c == 1) start = 1'b0;
            s_valid = (c >= 1 && c <= 20);
            #1;
            if (c == 0) begin
                check("cw_acc_clr", acc_clr, 1);
                check("cw_busy0",   busy,    0);
            end
            if (c >= 1 && c <= 20) begin
                check($sformatf("cw_rom_addr_c%0d", c), rom_addr, 96 + 4 * (c - 1));
                check($sformatf("cw_acc_en_c%0d", c),   acc_en,   1);
                check($sformatf("cw_z_idx_c%0d", c),    z_idx,    1);
            end
            if (c == 21) begin
                check("cw_solve_en",  solve_en, 1);
                check("cw_solve_rom", rom_addr, 176);
                check("cw_solve_rdy", s_ready,  0);
            end
            if (c >= 22 && c <= 25) begin
                check($sformatf("cw_m_valid_c%0d", c), m_valid, 1);
                check($sformatf("cw_par_sel_c%0d", c), par_sel, c - 22);
                check($sformatf("cw_m_last_c%0d", c),  m_last,  c == 25);
                check($sformatf("cw_done_c%0d", c),    done,    0);
            end
            if (c == 26) begin
                check("cw_done",    done,    1);
                check("cw_busy26",  busy,    0);
                check("cw_blk_end", blk_cnt, 0);
                check("cw_par_end", par_sel, 0);
            end
            @(negedge CLK);
        end

        // Bad req_z after a codeword: cfg_err pulses, z_idx keeps its last value.
        check("post_done_clear", done, 0);
        start = 1'b1;
        req_z = 3'b011;
        #1;
        check("bad_multi_cfg",  cfg_err, 1);
        check("bad_multi_clr",  acc_clr, 0);
        check("bad_multi_zidx", z_idx,   1);
        @(negedge CLK);
        req_z = 3'b000;
        #1;
        check("bad_zero_cfg",  cfg_err, 1);
        check("bad_zero_busy", busy,    0);
        @(negedge CLK);
        start = 1'b0;
        #1;
        check("bad_cfg_pulse", cfg_err, 0);
        check("bad_busy",      busy,    0);
        check("bad_zidx_held", z_idx,   1);
        @(negedge CLK);

        // Alternating s_valid: exactly NI beats accepted before the solve cycle.
        req_z = 3'b001;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cnt   = 0;
        seen  = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            s_valid = (c % 2 == 0);
            #1;
            if (solve_en) begin
                seen = 1;
                check("toggle_beats", cnt, NI);
                check("toggle_no_acc_in_solve", acc_en, 0);
            end
            if (acc_en) cnt++;
            @(negedge CLK);
        end
        check("toggle_solve_seen", seen, 1);
        drain("toggle_done");

        // Downstream stall for 3 cycles at par_sel=2 delays done to cycle 29.
        req_z = 3'b100;
        start = 1'b1;
        for (int c = 0; c <= 29; c++) begin
            if (c == 1) start = 1'b0;
            s_valid = (c >= 1 && c <= 20);
            m_ready = !(c >= 24 && c <= 26);
            #1;
            if (c >= 24 && c <= 26) begin
                check($sformatf("stall_valid_c%0d", c), m_valid, 1);
                check($sformatf("stall_par_c%0d", c),   par_sel, 2);
            end
            if (c == 27) check("stall_par_resume", par_sel, 2);
            if (c == 28) begin
                check("stall_par_last", par_sel, 3);
                check("stall_m_last",   m_last,  1);
            end
            if (c >= 26 && c <= 28) check($sformatf("stall_nodone_c%0d", c), done, 0);
            if (c == 29) check("stall_done", done, 1);
            @(negedge CLK);
        end

        // Asynchronous reset while emitting par_sel=1.
        req_z   = 3'b001;
        start   = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 23; c++) begin
            if (c == 1) start = 1'b0;
            s_valid = (c >= 1 && c <= 20);
            @(negedge CLK);
        end
        m_ready = 1'b0;
        s_valid = 1'b1;
        #1;
        check("rst_pre_par_sel", par_sel, 1);
        check("rst_pre_m_valid", m_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge CLK);
        rst_n   = 1'b1;
        s_valid = 1'b0;

        // Randomized run against the reference model, starting from reset state.
        md_active = 0;
        md_solved = 0;
        md_done   = 0;
        md_got    = 0;
        md_sent   = 0;
        md_zi     = 0;
        ncw       = 0;
        for (int c = 0; c < 800; c++) begin
            start   = ($urandom_range(0, 3) == 0);
            req_z   = ($urandom_range(0, 1) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = ($urandom_range(0, 9) < 7);
            #1;
            model_check();
            model_update();
            if (done) ncw++;
            @(negedge CLK);
        end
        check("rnd_codewords_ge2", ncw >= 2, 1);

`ifdef QCLDPC_SEQ_ABORT_EN
        // Abort at blk_cnt=7 together with a valid beat.
        do_reset();
        req_z = 3'b010;
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) start = 1'b0;
            s_valid = (c >= 1);
            @(negedge CLK);
        end
        s_valid = 1'b1;
        abort   = 1'b1;
        #1;
        check("abort_blk_pre", blk_cnt, 7);
        check("abort_acc_en",  acc_en,  0);
        check("abort_acc_clr", acc_clr, 1);
        @(negedge CLK);
        abort   = 1'b0;
        m_ready = 1'b1;
        #1;
        check("abort_busy", busy,    0);
        check("abort_blk",  blk_cnt, 0);
        check("abort_done", done,    0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (done) seen = 1;
            @(negedge CLK);
        end
        check("abort_no_done", seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
